// File: rtl/tdm_demux_1x4_pkg.sv
// Shared TDM definitions. The transmitter mux/counter and the demux both use them,
// so slot numbering and channel placement are the same on both ends of the link.
package tdm_pkg;

    localparam int CHANNELS = 4;
    localparam int SLOT_W   = 2;

    typedef enum logic {
        HUNT,
        LOCKED
    } state_e;

    // Bit offset of a channel inside a packed, slot-ordered word.
    function automatic int unsigned slot_lsb(input logic [SLOT_W-1:0] slot,
                                             input int unsigned       width);
        return int'(slot) * width;
    endfunction

endpackage

// File: rtl/tdm_demux_1x4_if.sv
// Serial TDM link on one side, parallel channel outputs on the other.
interface tdm_demux_1x4_if #(
    parameter int WIDTH = 1
);
    import tdm_pkg::*;

    logic [WIDTH-1:0]          In;
    logic                      In_valid;
    logic                      Frame_sync;
    logic [CHANNELS*WIDTH-1:0] Out;
    logic                      Out_valid;
    logic [SLOT_W-1:0]         Slot;
    logic                      Locked;
    logic                      Sync_err;

    modport master (
        output In, In_valid, Frame_sync,
        input  Out, Out_valid, Slot, Locked, Sync_err
    );

    modport slave (
        input  In, In_valid, Frame_sync,
        output Out, Out_valid, Slot, Locked, Sync_err
    );

endinterface

// File: rtl/tdm_demux_1x4_slot_decode.sv
// One-hot write-enable decoder: selects the channel register written by a beat.
module tdm_slot_decode
    import tdm_pkg::*;
(
    input  logic [SLOT_W-1:0]   slot,
    input  logic                en,
    output logic [CHANNELS-1:0] we
);

    always_comb begin
        we       = '0;
        we[slot] = en;
    end

endmodule

// File: rtl/tdm_demux_1x4.sv
// Four-channel TDM demultiplexer: locks on the slot-0 frame-sync marker, gathers a
// frame in shadow registers and publishes it in parallel with a one-cycle valid pulse.
module tdm_demux_1x4
    import tdm_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic           clk,
    input  logic           rst,
    tdm_demux_1x4_if.slave bus
);

    localparam int SHADOW_W = (CHANNELS - 1) * WIDTH;
    localparam int OUT_W    = CHANNELS * WIDTH;

    state_e                state_q, state_d;
    logic [SLOT_W-1:0]     slot_q, slot_d;
    logic [SHADOW_W-1:0]   shadow_q, shadow_d;
    logic [OUT_W-1:0]      out_q, out_d;
    logic                  out_valid_q, out_valid_d;
    logic                  sync_err_q, sync_err_d;

    logic                  sync_beat;
    logic                  wr_en;
    logic [SLOT_W-1:0]     wr_slot;
    logic [CHANNELS-1:0]   we;

    // A sync beat always restarts the frame at slot 0, whatever the counter says.
    assign sync_beat = bus.In_valid & bus.Frame_sync;
    assign wr_slot   = bus.Frame_sync ? '0 : slot_q;
    assign wr_en     = bus.In_valid & (bus.Frame_sync | (state_q == LOCKED));

    tdm_slot_decode u_slot_decode (
        .slot (wr_slot),
        .en   (wr_en),
        .we   (we)
    );

    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        shadow_d    = shadow_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        sync_err_d  = 1'b0;

        for (int k = 0; k < CHANNELS - 1; k++) begin
            if (we[k]) begin
                shadow_d[slot_lsb(SLOT_W'(k), WIDTH) +: WIDTH] = bus.In;
            end
        end

        // The last slot is never shadowed; it goes straight into the published frame.
        if (we[CHANNELS-1]) begin
            out_d       = {bus.In, shadow_q};
            out_valid_d = 1'b1;
        end

        case (state_q)
            HUNT: begin
                if (sync_beat) begin
                    state_d = LOCKED;
                    slot_d  = SLOT_W'(1);
                end
            end
            LOCKED: begin
                if (sync_beat) begin
                    sync_err_d = (slot_q != '0);
                    slot_d     = SLOT_W'(1);
                end else if (bus.In_valid) begin
                    slot_d = slot_q + SLOT_W'(1);
                end
            end
            default: begin
                state_d = HUNT;
                slot_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= HUNT;
            slot_q      <= '0;
            shadow_q    <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            sync_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            shadow_q    <= shadow_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            sync_err_q  <= sync_err_d;
        end
    end

    assign bus.Out       = out_q;
    assign bus.Out_valid = out_valid_q;
    assign bus.Slot      = slot_q;
    assign bus.Locked    = (state_q == LOCKED);
    assign bus.Sync_err  = sync_err_q;

endmodule

// File: doc/tdm_demux_1x4.md
# tdm_demux_1x4

Four-channel time-division demultiplexer: the receiving end of a TDM link whose transmitter serializes four channels onto one line through a 4-to-1 mux driven by a 2-bit slot counter. The block locks to a frame-sync marker on slot 0 and steers each valid beat into its channel register. It presents all four channels in parallel, with a one-cycle frame-valid pulse per complete frame. It sits between the serial link and the parallel consumer logic.

## Interface
- WIDTH, 1, bit width of one channel sample
- clk  input  1  system clock; all logic is rising-edge
- rst  input  1  synchronous, active-high reset
- In  input  WIDTH  serial TDM data, one channel sample per valid beat
- In_valid  input  1  In carries a sample this cycle
- Frame_sync  input  1  qualified by In_valid; marks the beat as slot 0
- Out  output  4*WIDTH  channel k at Out[k*WIDTH +: WIDTH]; last complete frame
- Out_valid  output  1  one-cycle pulse: Out updated with a new frame
- Slot  output  2  slot index expected for the next valid beat
- Locked  output  1  1 while in LOCKED state
- Sync_err  output  1  one-cycle pulse: sync seen on a slot other than 0 while locked

## Operation
- States: HUNT and LOCKED. Reset enters HUNT.
- Reset values: Out=0, Out_valid=0, Slot=0, Locked=0, Sync_err=0. Shadow registers are 0.
- HUNT:
  - Beats without Frame_sync are discarded.
  - On In_valid & Frame_sync: store In into shadow slot 0, set Slot=1, go to LOCKED.
- LOCKED, on each In_valid beat without Frame_sync:
  - Store In into shadow[Slot], then Slot = Slot+1 mod 4.
  - On the slot-3 beat: Out <= {In, shadow[2], shadow[1], shadow[0]} and Out_valid pulses.
- LOCKED, on In_valid & Frame_sync:
  - If Slot==0: normal slot-0 beat.
  - If Slot!=0: Sync_err pulses and the partial frame is dropped (Out unchanged, no Out_valid). The beat is stored as the new slot 0 and Slot=1. Locked stays 1.
- Frame_sync with In_valid=0 is ignored in every state.
- In_valid=0 cycles stall the frame. Slot and the shadow registers hold, with no timeout.
- Out holds its value until the next complete frame. Out is never cleared except by rst.
- Slot-3 beat carrying Frame_sync: this is a sync error. The frame is not emitted.

## Timing
- Every output is registered.
- Latency: slot-3 beat sampled at edge t -> Out/Out_valid visible after edge t, i.e. one cycle.
- Sync_err appears in the same cycle as the Slot update for the offending beat.
- Out_valid and Sync_err are never high for more than one consecutive cycle per event. They are never both high.
- Back-to-back frames at full rate (In_valid held 1): Out_valid pulses every 4 cycles.
- rst mid-frame:
  - Next cycle is in HUNT with all reset values.
  - No Out_valid for the interrupted frame.
  - A Frame_sync beat on the cycle after rst deasserts is accepted.

## Structure
- Shared package tdm_pkg holds:
  - CHANNELS=4 and SLOT_W=2
  - the state enum {HUNT, LOCKED}
  - the slot-to-bit-offset helper
- The transmitter-side mux/counter reuses this package so slot numbering matches on both ends.
- One sub-module: tdm_slot_decode, a 2-to-4 one-hot write-enable decoder (Slot, enable -> 4 enables), driving the shadow registers.
- Top level holds the FSM, the slot counter, the shadow registers and the output registers.

## Test plan
- Lock and one frame (WIDTH=4): rst, then beats A,B,C,D with Frame_sync on A -> Out=0xDCBA, Out_valid one pulse one cycle after D, Locked=1.
- HUNT discard: beats 1,2,3 without sync, then sync frame 4,5,6,7 -> Out=0x7654, exactly one Out_valid.
- Stalls: the same frame with In_valid gaps of 0-3 cycles between beats -> identical Out, one pulse, Slot frozen during gaps.
- Misaligned sync: after 2 locked beats, sync beat E then F,G,H -> Sync_err pulse on E, no Out_valid for the partial frame, then Out=0xHGFE with one pulse.
- Full-rate stream: 3 consecutive frames -> Out_valid every 4th cycle, each Out matches its frame.
- Reset mid-frame: rst after slot 2 -> all outputs 0, Locked=0, and the next sync frame is captured correctly.
